vga_sync_gen: RTL and testbench

//   Free-running raster timing generator for the VGA path. Produces hsync,

---
 rtl/vga_sync_gen.sv | 142 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Free-running raster timing generator. A horizontal counter (x) walks
//   every pixel clock and a vertical counter (y) advances once per line.
//   Every output is decoded from the next counter value and registered, so
//   the outputs line up with x/y in the same cycle and nothing downstream
//   sees a combinational compare path.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset, released synchronously
//   hsync        horizontal sync, active level set by SYNC_POL
//   vsync        vertical sync, active level set by SYNC_POL
//   blank        1 outside the visible area
//   x            horizontal position, 0..H_TOTAL-1
//   y            vertical position, 0..V_TOTAL-1
//   line_start   high for the single cycle where x==0
//   frame_start  high for the single cycle where x==0 and y==0
//   frame_count  frames completed since reset, modulo 256

module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The counters are 10 bits wide, so longer rasters cannot be represented.
    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_sync_gen: H_TOTAL must not exceed 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_sync_gen: V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Compare bounds carry an extra bit: a sync window ending exactly at
    // 1024 must not wrap to zero.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank;
    logic       r_line_start;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_blank_nxt;

    // Next-state counter values and the output decode built from them.
    always_comb begin
        w_h_wrap = (r_x == H_LAST);
        w_v_wrap = w_h_wrap && (r_y == V_LAST);
        w_x_nxt  = w_h_wrap ? 10'd0 : r_x + 10'd1;
        if (w_v_wrap) begin
            w_y_nxt = 10'd0;
        end else if (w_h_wrap) begin
            w_y_nxt = r_y + 10'd1;
        end else begin
            w_y_nxt = r_y;
        end
        w_x_ext     = {1'b0, w_x_nxt};
        w_y_ext     = {1'b0, w_y_nxt};
        w_hs_act    = (w_x_ext >= HS_BEGIN) && (w_x_ext < HS_END);
        // y only moves at x wrap, so vsync naturally changes on whole lines.
        w_vs_act    = (w_y_ext >= VS_BEGIN) && (w_y_ext < VS_END);
        w_blank_nxt = (w_x_ext >= H_ACT_END) || (w_y_ext >= V_ACT_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_hsync       <= SYNC_OFF;
            r_vsync       <= SYNC_OFF;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_count <= 8'd0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hsync       <= w_hs_act ? SYNC_ON : SYNC_OFF;
            r_vsync       <= w_vs_act ? SYNC_ON : SYNC_OFF;
            r_blank       <= w_blank_nxt;
            r_line_start  <= (w_x_nxt == 10'd0);
            r_frame_start <= w_v_wrap;
            // Counts the frame just finished, landing with frame_start.
            if (w_v_wrap) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blank       = r_blank;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Two instances with a reduced raster (16 x 10)
// run side by side, one per sync polarity, and are compared every cycle
// against a model that derives position purely from elapsed clocks since
// reset. Random asynchronous reset pulses are injected mid-frame.
module tb_vga_sync_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 16
    localparam int VT = VA + VF + VS + VB;   // 10
    localparam int FT = HT * VT;             // 160

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       hs0, vs0, bl0, ls0, fs0;
    logic [9:0] x0, y0;
    logic [7:0] fc0;
    logic       hs1, vs1, bl1, ls1, fs1;
    logic [9:0] x1, y1;
    logic [7:0] fc1;

    int n_chk = 0;
    int n_err = 0;
    int t = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .hsync(hs0), .vsync(vs0), .blank(bl0),
        .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
    );

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .hsync(hs1), .vsync(vs1), .blank(bl1),
        .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Clocks elapsed since reset release; reset forces it back to zero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    task automatic cmp_all(input string tag, input int pol,
                           input logic [9:0] ax, input logic [9:0] ay,
                           input logic ahs, input logic avs, input logic abl,
                           input logic als, input logic afs, input logic [7:0] afc);
        int ex, ey, efc;
        logic hs_on, vs_on;
        ex    = t % HT;
        ey    = (t / HT) % VT;
        efc   = (t / FT) % 256;
        hs_on = (ex >= HA + HF) && (ex < HA + HF + HS);
        vs_on = (ey >= VA + VF) && (ey < VA + VF + VS);
        chk({tag, ".x"}, 32'(ax), 32'(ex));
        chk({tag, ".y"}, 32'(ay), 32'(ey));
        chk({tag, ".blank"}, 32'(abl), 32'((ex >= HA) || (ey >= VA)));
        chk({tag, ".hsync"}, 32'(ahs), 32'((pol != 0) ? hs_on : !hs_on));
        chk({tag, ".vsync"}, 32'(avs), 32'((pol != 0) ? vs_on : !vs_on));
        chk({tag, ".line_start"}, 32'(als), 32'(ex == 0));
        chk({tag, ".frame_start"}, 32'(afs), 32'((ex == 0) && (ey == 0)));
        chk({tag, ".frame_count"}, 32'(afc), 32'(efc));
    endtask

    always @(negedge clk) begin
        cmp_all("pol0", 0, x0, y0, hs0, vs0, bl0, ls0, fs0, fc0);
        cmp_all("pol1", 1, x1, y1, hs1, vs1, bl1, ls1, fs1, fc1);
    end

    // First-frame statistics for the literal checks.
    int hs_cnt = 0, hs_x = -1, hs1_cnt = 0;
    int vs_cnt = 0, vs_x = -1, vs_y = -1;
    int bl_cnt = 0, rise_x = -1, ls_cnt = 0, fs_cnt = 0;
    int x_last = -1, x_wrap = -1, y_wrap = -1;

    task automatic record(input int i);
        if (!hs0 && y0 == 10'd0) begin
            if (hs_cnt == 0) hs_x = int'(x0);
            hs_cnt++;
        end
        if (hs1 && y1 == 10'd0) hs1_cnt++;
        if (!vs0) begin
            if (vs_cnt == 0) begin
                vs_x = int'(x0);
                vs_y = int'(y0);
            end
            vs_cnt++;
        end
        if (bl0) bl_cnt++;
        if (bl0 && y0 == 10'd0 && rise_x < 0) rise_x = int'(x0);
        if (ls0) ls_cnt++;
        if (fs0) fs_cnt++;
        if (i == HT - 1) x_last = int'(x0);
        if (i == HT) begin
            x_wrap = int'(x0);
            y_wrap = int'(y0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".x"}, 32'(x0), 0);
        chk({tag, ".y"}, 32'(y0), 0);
        chk({tag, ".blank"}, 32'(bl0), 0);
        chk({tag, ".hsync0"}, 32'(hs0), 1);
        chk({tag, ".vsync0"}, 32'(vs0), 1);
        chk({tag, ".hsync1"}, 32'(hs1), 0);
        chk({tag, ".vsync1"}, 32'(vs1), 0);
        chk({tag, ".line_start"}, 32'(ls0), 1);
        chk({tag, ".frame_start"}, 32'(fs0), 1);
        chk({tag, ".frame_count"}, 32'(fc0), 0);
    endtask

    initial begin
        bit found;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_reset_state("release");
        record(0);
        for (int i = 1; i < FT; i++) begin
            @(negedge clk);
            #1;
            record(i);
        end
        chk("hsync_low_clocks", hs_cnt, HS);
        chk("hsync_first_x", hs_x, HA + HF);
        chk("hsync1_high_clocks", hs1_cnt, HS);
        chk("vsync_low_clocks", vs_cnt, VS * HT);
        chk("vsync_first_y", vs_y, VA + VF);
        chk("vsync_first_x", vs_x, 0);
        chk("blank_clocks", bl_cnt, FT - HA * VA);
        chk("blank_rise_x", rise_x, HA);
        chk("line_starts", ls_cnt, VT);
        chk("frame_starts", fs_cnt, 1);
        chk("x_before_wrap", x_last, HT - 1);
        chk("x_after_wrap", x_wrap, 0);
        chk("y_after_wrap", y_wrap, 1);

        @(negedge clk);
        #1;
        chk("frame1_start", 32'(fs0), 1);
        chk("frame1_count", 32'(fc0), 1);
        repeat (254 * FT) @(negedge clk);
        #1;
        chk("frame255_count", 32'(fc0), 255);
        repeat (FT) @(negedge clk);
        #1;
        chk("frame256_count", 32'(fc0), 0);
        chk("frame256_start", 32'(fs0), 1);

        // Reset landing mid-frame, between edges.
        found = 1'b0;
        for (int k = 0; k < 2 * FT; k++) begin
            @(negedge clk);
            if (x0 == 10'd11 && y0 == 10'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_x11_y5", 32'(found), 1);
        chk("pre_reset_blank", 32'(bl0), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_reset_state("rerelease");
        @(negedge clk);
        #1;
        chk("after_rerelease_x", 32'(x0), 1);
        chk("after_rerelease_ls", 32'(ls0), 0);

        // Random reset pulses at random points in the raster.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            #($urandom_range(1, 3)) rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (2 * FT) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
